rr_chan_mux: RTL and testbench
==============================

Name: rr_chan_mux

Overview:
- N-channel valid/ready multiplexer. Per-channel inputs are unpacked arrays of a parametrised element width.
- Arbitration is round-robin or fixed-priority, selected by parameter.
- The winning element is pushed into a 2-entry output buffer. That buffer gives full throughput and no combinational path from out_ready to in_ready.
- The block sits between several producer lanes and one consumer lane.

Parameters:
- N_CH, 4, number of input channels (>=1).
- DATA_W, 32, width of each channel element.
- MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins).
- CH_W, ($clog2(N_CH) > 0 ? $clog2(N_CH) : 1), width of the channel index. Derived; do not override.

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1 x [N_CH] unpacked  per-channel element valid
- in_data  input  DATA_W x [N_CH] unpacked  per-channel element
- in_ready  output  1 x [N_CH] unpacked  per-channel accept, one-hot or zero
- out_valid  output  1  buffer head valid
- out_data  output  DATA_W  buffer head element
- out_chan  output  CH_W  source channel of the head element
- out_ready  input  1  consumer accept

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately regardless of clk):
  - count=0, rr_ptr=0.
  - Both buffer slots cleared to data=0, chan=0.
  - out_valid=0, out_data=0, out_chan=0, all in_ready=0.
  - Any in-flight elements are discarded. Release is synchronous to the next clk edge.
- can_push = (count < 2). It is a function of registered state only; it never depends on out_ready.
- Winner selection (combinational):
  - MODE=0: the first i with in_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod N_CH.
  - MODE=1: the lowest i with in_valid[i]=1; rr_ptr is unused.
- in_ready[i] = can_push && (i == winner) && in_valid[i]. All in_ready are 0 when no in_valid is set or count==2.
- Push: any in_valid[i] && in_ready[i] on a clk edge. {in_data[winner], winner} is written to the tail slot.
- Pop: out_valid && out_ready on a clk edge. The head is removed and the second slot, if any, becomes head.
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop on the same edge: unchanged
  - pop on empty: impossible (out_valid=0)
  - push at count 2: impossible (in_ready=0)
- Latency: an element pushed on edge t appears at out_* after edge t (registered) when the buffer was empty. Minimum latency is 1 cycle.
- Throughput: count=1 with simultaneous push and pop every cycle sustains 1 element/cycle.
- out_valid = (count != 0). out_data/out_chan reflect the head slot. They hold stable while out_valid && !out_ready.
- rr_ptr update (MODE=0): on push, rr_ptr <= (winner+1) mod N_CH. Wrap from N_CH-1 goes to 0. It is unchanged when there is no push.
- N_CH=1: winner is always 0, out_chan is always 0, and CH_W=1.
- Ordering: the output order equals the push order; there is no reordering.
- Inputs are not required to hold in_valid when in_ready=0. The block makes no assumption about producer stickiness.

Test Plan:
- Reset: drive data during reset with rst_n=0 mid-cycle. Required: out_valid=0, out_data=0, out_chan=0 and in_ready all 0 immediately, with no clk edge needed.
- Single channel latency: N_CH=4, MODE=0, out_ready=1, ch2 presents 0xA5A5_0001 for one cycle. Required: in_ready[2]=1 that cycle; out_valid=1 with out_data=0xA5A5_0001, out_chan=2 the next cycle; rr_ptr=3.
- Round-robin fairness: all 4 channels valid continuously, out_ready=1, rr_ptr=0. Required: out_chan sequence 0,1,2,3,0,1 over 6 consecutive cycles; one grant per cycle; wrap 3->0 correct.
- Backpressure/full:
  - Stimulus: out_ready=0, ch1 and ch3 valid.
  - Required:
    - pushes ch1 then ch3.
    - count=2.
    - all in_ready=0 thereafter.
    - out_data/out_chan held at ch1.
  - Then raise out_ready for 1 cycle. Required: pop ch1, head becomes ch3, and a new push is allowed the following cycle.
- Fixed priority: MODE=1, ch0 and ch3 valid continuously, out_ready=1. Required: only ch0 is granted and ch3 in_ready stays 0. Drop ch0 and ch3 is granted the next cycle.
- Reset mid-operation: count=2, assert rst_n=0 for 1 cycle. Required: buffer empty, rr_ptr=0, no stale element emitted after release; the first post-reset push appears with correct data.

Source files
------------

// File: rtl/rr_chan_mux_if.sv
// Bus bundle for rr_chan_mux: N producer lanes (valid/data/ready per lane)
// and one consumer lane (valid/data/chan/ready).
interface rr_chan_mux_if #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 32,
  parameter int CH_W   = ($clog2(N_CH) > 0 ? $clog2(N_CH) : 1)
);
  logic              in_valid [N_CH];
  logic [DATA_W-1:0] in_data  [N_CH];
  logic              in_ready [N_CH];
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [CH_W-1:0]   out_chan;
  logic              out_ready;

  // The mux itself: consumes producer lanes, drives the consumer lane.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_chan
  );

  // The environment: producers and consumer.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_chan
  );
endinterface

// File: rtl/rr_chan_mux.sv
// N-channel valid/ready multiplexer with round-robin (MODE=0) or
// fixed-priority (MODE=1) arbitration feeding a 2-entry output buffer.
// in_ready depends only on registered occupancy, so there is no
// combinational path from out_ready back to the producers.
module rr_chan_mux #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 32,
  parameter int MODE   = 0,
  parameter int CH_W   = ($clog2(N_CH) > 0 ? $clog2(N_CH) : 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  rr_chan_mux_if.slave  bus
);

  logic [1:0]        r_count;
  logic [CH_W-1:0]   r_rr_ptr;
  logic [DATA_W-1:0] r_data [2];
  logic [CH_W-1:0]   r_chan [2];

  logic              w_can_push;
  logic              w_found;
  logic              w_push;
  logic              w_pop;
  logic              w_tail;
  logic [CH_W-1:0]   w_winner;
  logic [CH_W-1:0]   w_next_ptr;
  logic [DATA_W-1:0] w_win_data;
  int                w_start;

  // Gated by rst_n so that no lane is offered a grant while held in reset.
  assign w_can_push = rst_n && (r_count < 2'd2);
  assign w_pop      = (r_count != 2'd0) && bus.out_ready;
  assign w_push     = w_can_push && w_found;
  // Tail slot index after this edge's pop: only slot 1 when one entry stays.
  assign w_tail     = (r_count == 2'd1) && !w_pop;
  assign w_start    = (MODE == 0) ? int'(r_rr_ptr) : 0;
  assign w_next_ptr = (w_winner == CH_W'(N_CH - 1)) ? '0 : w_winner + CH_W'(1);

  // Winner scan: lowest valid lane at or above the start point, otherwise
  // the lowest valid lane overall (the wrapped part of the rotation).
  always_comb begin
    w_found    = 1'b0;
    w_winner   = '0;
    w_win_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (!w_found && bus.in_valid[i] && (i >= w_start)) begin
        w_found    = 1'b1;
        w_winner   = CH_W'(i);
        w_win_data = bus.in_data[i];
      end
    end
    for (int i = 0; i < N_CH; i++) begin
      if (!w_found && bus.in_valid[i]) begin
        w_found    = 1'b1;
        w_winner   = CH_W'(i);
        w_win_data = bus.in_data[i];
      end
    end
  end

  // One-hot (or zero) accept towards the producers.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      bus.in_ready[i] = w_can_push && w_found && bus.in_valid[i] &&
                        (w_winner == CH_W'(i));
    end
  end

  // Buffer occupancy: simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Round-robin pointer moves just past the lane that was granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if ((MODE == 0) && w_push) begin
      r_rr_ptr <= w_next_ptr;
    end
  end

  // Two-slot buffer with the head always in slot 0; a pop shifts slot 1 down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < 2; s++) begin
        r_data[s] <= '0;
        r_chan[s] <= '0;
      end
    end else begin
      if (w_push && !w_tail) begin
        r_data[0] <= w_win_data;
        r_chan[0] <= w_winner;
      end else if (w_pop) begin
        r_data[0] <= r_data[1];
        r_chan[0] <= r_chan[1];
      end
      if (w_push && w_tail) begin
        r_data[1] <= w_win_data;
        r_chan[1] <= w_winner;
      end
    end
  end

  assign bus.out_valid = (r_count != 2'd0);
  assign bus.out_data  = r_data[0];
  assign bus.out_chan  = r_chan[0];

endmodule

// File: tb/tb_rr_chan_mux.sv
// Self-checking bench for rr_chan_mux. Two instances share clock and reset:
// dut0 is round-robin, dut1 is fixed priority. A queue-based reference model
// tracks the buffer contents and arbitration pointer of whichever instance
// is currently selected.
module tb_rr_chan_mux;

  localparam int NC = 4;
  localparam int DW = 32;

  logic clk;
  logic rst_n;

  rr_chan_mux_if #(.N_CH(NC), .DATA_W(DW)) bus0 ();
  rr_chan_mux_if #(.N_CH(NC), .DATA_W(DW)) bus1 ();

  rr_chan_mux #(.N_CH(NC), .DATA_W(DW), .MODE(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  rr_chan_mux #(.N_CH(NC), .DATA_W(DW), .MODE(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    chan;
    logic [DW-1:0] data;
  } elem_t;

  elem_t         mq[$];
  int            m_ptr;
  int            sel;
  int            checks;
  int            errors;

  logic          drv_valid [NC];
  logic [DW-1:0] drv_data  [NC];
  logic          drv_ready;

  logic          obs_rdy   [NC];
  logic          obs_valid;
  logic [DW-1:0] obs_data;
  logic [1:0]    obs_chan;

  // Reference arbitration: first requesting lane in rotation order from the
  // pointer (round-robin) or from lane 0 (fixed priority); -1 if none.
  function automatic int model_pick();
    for (int k = 0; k < NC; k++) begin
      int idx;
      idx = (sel == 0) ? (m_ptr + k) % NC : k;
      if (drv_valid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic clear_drivers();
    for (int i = 0; i < NC; i++) begin
      drv_valid[i] = 1'b0;
      drv_data[i]  = '0;
    end
    drv_ready = 1'b1;
  endtask

  // One clock cycle: drive the selected DUT, compare against the model
  // before the edge, then advance the model across the edge.
  task automatic run_cycle(input string tag);
    int    w;
    bit    can;
    bit    exp_rdy;
    bit    do_pop;
    elem_t e;
    for (int i = 0; i < NC; i++) begin
      bus0.in_valid[i] = (sel == 0) ? drv_valid[i] : 1'b0;
      bus0.in_data[i]  = (sel == 0) ? drv_data[i]  : '0;
      bus1.in_valid[i] = (sel == 1) ? drv_valid[i] : 1'b0;
      bus1.in_data[i]  = (sel == 1) ? drv_data[i]  : '0;
    end
    bus0.out_ready = (sel == 0) ? drv_ready : 1'b1;
    bus1.out_ready = (sel == 1) ? drv_ready : 1'b1;
    #1;
    for (int i = 0; i < NC; i++)
      obs_rdy[i] = (sel == 0) ? bus0.in_ready[i] : bus1.in_ready[i];
    obs_valid = (sel == 0) ? bus0.out_valid : bus1.out_valid;
    obs_data  = (sel == 0) ? bus0.out_data  : bus1.out_data;
    obs_chan  = (sel == 0) ? bus0.out_chan  : bus1.out_chan;

    can = (mq.size() < 2);
    w   = model_pick();
    for (int i = 0; i < NC; i++) begin
      exp_rdy = can && (w == i);
      checks++;
      if (obs_rdy[i] !== exp_rdy) begin
        errors++;
        $display("[TB] FAIL %s in_ready[%0d]: got %b expected %b", tag, i, obs_rdy[i], exp_rdy);
      end
    end
    checks++;
    if (obs_valid !== (mq.size() > 0)) begin
      errors++;
      $display("[TB] FAIL %s out_valid: got %b expected %b", tag, obs_valid, mq.size() > 0);
    end
    if (mq.size() > 0) begin
      checks++;
      if (obs_data !== mq[0].data || obs_chan !== mq[0].chan) begin
        errors++;
        $display("[TB] FAIL %s head: got data %h chan %0d expected data %h chan %0d",
                 tag, obs_data, obs_chan, mq[0].data, mq[0].chan);
      end
    end

    do_pop = (mq.size() > 0) && drv_ready;
    @(posedge clk);
    if (do_pop) void'(mq.pop_front());
    if (can && w >= 0) begin
      e.chan = 2'(w);
      e.data = drv_data[w];
      mq.push_back(e);
      if (sel == 0) m_ptr = (w + 1) % NC;
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    clear_drivers();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    m_ptr = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    sel = 0;
    drv_ready    = 1'b0;
    drv_valid[0] = 1'b1;
    drv_data[0]  = 32'hDEAD_0000 | DW'($urandom_range(0, 255));
    run_cycle("rst_fill0");
    run_cycle("rst_fill1");
    for (int i = 0; i < NC; i++) begin
      bus0.in_valid[i] = 1'b1;
      bus0.in_data[i]  = $urandom;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus0.out_valid !== 1'b0 || bus0.out_data !== '0 || bus0.out_chan !== '0) begin
      errors++;
      $display("[TB] FAIL reset_async outputs: got valid %b data %h chan %0d expected 0 0 0",
               bus0.out_valid, bus0.out_data, bus0.out_chan);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NC; i++) begin
      checks++;
      if (bus0.in_ready[i] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_hold in_ready[%0d]: got %b expected 0", i, bus0.in_ready[i]);
      end
    end
    checks++;
    if (bus0.out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_hold out_valid: got %b expected 0", bus0.out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    m_ptr = 0;
    clear_drivers();
    run_cycle("rst_release");
  endtask

  task automatic test_single_latency();
    apply_reset();
    sel = 0;
    run_cycle("lat_idle");
    drv_valid[2] = 1'b1;
    drv_data[2]  = 32'hA5A5_0001;
    run_cycle("lat_push");
    checks++;
    if (obs_rdy[2] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL lat_grant in_ready[2]: got %b expected 1", obs_rdy[2]);
    end
    clear_drivers();
    run_cycle("lat_out");
    checks++;
    if (obs_valid !== 1'b1 || obs_data !== 32'hA5A5_0001 || obs_chan !== 2'd2) begin
      errors++;
      $display("[TB] FAIL lat_out: got valid %b data %h chan %0d expected 1 a5a50001 2",
               obs_valid, obs_data, obs_chan);
    end
    for (int i = 0; i < NC; i++) begin
      drv_valid[i] = 1'b1;
      drv_data[i]  = $urandom;
    end
    run_cycle("lat_ptr");
    checks++;
    if (obs_rdy[3] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL lat_rr_ptr in_ready[3]: got %b expected 1", obs_rdy[3]);
    end
    clear_drivers();
    run_cycle("lat_drain0");
    run_cycle("lat_drain1");
  endtask

  task automatic test_rr_fairness();
    int exp_seq [6];
    int grants;
    exp_seq = '{0, 1, 2, 3, 0, 1};
    apply_reset();
    sel = 0;
    for (int i = 0; i < NC; i++) drv_valid[i] = 1'b1;
    for (int c = 0; c < 7; c++) begin
      for (int i = 0; i < NC; i++) drv_data[i] = {8'(c), 8'(i), 16'($urandom)};
      run_cycle("rr");
      grants = 0;
      for (int i = 0; i < NC; i++) grants += int'(obs_rdy[i] === 1'b1);
      checks++;
      if (grants != 1) begin
        errors++;
        $display("[TB] FAIL rr_one_grant cycle %0d: got %0d grants expected 1", c, grants);
      end
      if (c >= 1) begin
        checks++;
        if (obs_valid !== 1'b1 || obs_chan !== 2'(exp_seq[c-1])) begin
          errors++;
          $display("[TB] FAIL rr_seq cycle %0d: got valid %b chan %0d expected 1 %0d",
                   c, obs_valid, obs_chan, exp_seq[c-1]);
        end
      end
    end
    clear_drivers();
    run_cycle("rr_drain0");
    run_cycle("rr_drain1");
  endtask

  task automatic test_backpressure();
    apply_reset();
    sel = 0;
    drv_ready    = 1'b0;
    drv_valid[1] = 1'b1;
    drv_valid[3] = 1'b1;
    drv_data[1]  = 32'h1111_0000 | DW'($urandom_range(0, 4095));
    drv_data[3]  = 32'h3333_0000 | DW'($urandom_range(0, 4095));
    run_cycle("bp_push1");
    checks++;
    if (obs_rdy[1] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_first in_ready[1]: got %b expected 1", obs_rdy[1]);
    end
    run_cycle("bp_push3");
    checks++;
    if (obs_rdy[3] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_second in_ready[3]: got %b expected 1", obs_rdy[3]);
    end
    for (int c = 0; c < 2; c++) begin
      run_cycle("bp_full");
      checks++;
      if (obs_rdy[1] !== 1'b0 || obs_rdy[3] !== 1'b0 || obs_chan !== 2'd1) begin
        errors++;
        $display("[TB] FAIL bp_full: got rdy1 %b rdy3 %b chan %0d expected 0 0 1",
                 obs_rdy[1], obs_rdy[3], obs_chan);
      end
    end
    drv_ready = 1'b1;
    run_cycle("bp_pop");
    drv_ready = 1'b0;
    run_cycle("bp_after");
    checks++;
    if (obs_chan !== 2'd3 || obs_rdy[1] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_after: got chan %0d rdy1 %b expected 3 1", obs_chan, obs_rdy[1]);
    end
    clear_drivers();
    run_cycle("bp_drain0");
    run_cycle("bp_drain1");
  endtask

  task automatic test_fixed_priority();
    apply_reset();
    sel = 1;
    drv_valid[0] = 1'b1;
    drv_valid[3] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      drv_data[0] = $urandom;
      drv_data[3] = $urandom;
      run_cycle("fp_both");
      checks++;
      if (obs_rdy[0] !== 1'b1 || obs_rdy[3] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL fp_prio cycle %0d: got rdy0 %b rdy3 %b expected 1 0",
                 c, obs_rdy[0], obs_rdy[3]);
      end
    end
    drv_valid[0] = 1'b0;
    drv_data[3]  = 32'hC3C3_0003;
    run_cycle("fp_ch3");
    checks++;
    if (obs_rdy[3] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL fp_ch3_grant: got %b expected 1", obs_rdy[3]);
    end
    clear_drivers();
    run_cycle("fp_drain0");
    run_cycle("fp_drain1");
  endtask

  task automatic test_reset_mid();
    apply_reset();
    sel = 0;
    drv_ready    = 1'b0;
    drv_valid[0] = 1'b1;
    drv_valid[1] = 1'b1;
    drv_data[0]  = $urandom;
    drv_data[1]  = $urandom;
    run_cycle("rm_fill0");
    run_cycle("rm_fill1");
    drv_ready      = 1'b1;
    bus0.out_ready = 1'b1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    m_ptr = 0;
    clear_drivers();
    run_cycle("rm_empty0");
    run_cycle("rm_empty1");
    drv_valid[1] = 1'b1;
    drv_valid[3] = 1'b1;
    drv_data[1]  = 32'h5EED_0001;
    drv_data[3]  = 32'h5EED_0003;
    run_cycle("rm_push");
    checks++;
    if (obs_rdy[1] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rm_ptr_reset in_ready[1]: got %b expected 1", obs_rdy[1]);
    end
    clear_drivers();
    run_cycle("rm_out");
    checks++;
    if (obs_valid !== 1'b1 || obs_data !== 32'h5EED_0001 || obs_chan !== 2'd1) begin
      errors++;
      $display("[TB] FAIL rm_first: got valid %b data %h chan %0d expected 1 5eed0001 1",
               obs_valid, obs_data, obs_chan);
    end
    run_cycle("rm_drain");
  endtask

  task automatic test_random();
    for (int m = 0; m < 2; m++) begin
      apply_reset();
      sel = m;
      for (int c = 0; c < 300; c++) begin
        for (int i = 0; i < NC; i++) begin
          drv_valid[i] = 1'($urandom_range(0, 1));
          drv_data[i]  = $urandom;
        end
        drv_ready = ($urandom_range(0, 3) != 0);
        run_cycle(m == 0 ? "rand_rr" : "rand_fp");
      end
      clear_drivers();
      for (int c = 0; c < 3; c++) run_cycle("rand_drain");
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    sel    = 0;
    m_ptr  = 0;
    clear_drivers();
    for (int i = 0; i < NC; i++) begin
      bus0.in_valid[i] = 1'b0;
      bus0.in_data[i]  = '0;
      bus1.in_valid[i] = 1'b0;
      bus1.in_data[i]  = '0;
    end
    bus0.out_ready = 1'b1;
    bus1.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] starting");
    test_reset();
    test_single_latency();
    test_rr_fairness();
    test_backpressure();
    test_fixed_priority();
    test_reset_mid();
    test_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
